// File: rtl/ad9361_rx_cpack_pkg.sv
// Shared widths and enable-mask helpers for the AD9361 receive channel packer.
package ad9361_rx_cpack_pkg;

  localparam int LANE_W = 16;
  localparam int WORD_W = 64;
  localparam int LANES  = 4;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  // Only counts that divide the four lanes evenly can be packed.
  function automatic logic count_ok(input logic [2:0] n);
    return (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
  endfunction

endpackage

// File: rtl/ad9361_rx_cpack_fifo.sv
// Word FIFO with a registered head: an entry becomes visible one cycle after it is written.
module ad9361_rx_cpack_fifo
  import ad9361_rx_cpack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o,
  output logic              drop_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d, avail;
  logic              valid_q, valid_d, push, pop;
  logic [WORD_W-1:0] data_q;

  always_comb begin
    full_o   = (cnt_q == DEPTH_C);
    pop      = valid_q & rd_ready_i;
    push     = wr_i & (~full_o | pop);
    drop_o   = wr_i & full_o & ~pop;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // Entries written at this edge are excluded so the head lags the write by a cycle.
    avail    = cnt_q - (AW+1)'(pop);
    valid_d  = (avail != '0);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      if (valid_d) data_q <= mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ad9361_rx_cpack.sv
// Packs the enabled AD9361 receive channels into 64-bit words and buffers them for the DMA.
module ad9361_rx_cpack
  import ad9361_rx_cpack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        adc_clk,
  input  logic        adc_rstn,
  input  logic        adc_enable_i0,
  input  logic        adc_enable_q0,
  input  logic        adc_enable_i1,
  input  logic        adc_enable_q1,
  input  logic        adc_valid_i0,
  input  logic        adc_valid_q0,
  input  logic        adc_valid_i1,
  input  logic        adc_valid_q1,
  input  logic [15:0] adc_data_i0,
  input  logic [15:0] adc_data_q0,
  input  logic [15:0] adc_data_i1,
  input  logic [15:0] adc_data_q1,
  output logic        pack_valid,
  input  logic        pack_ready,
  output logic [63:0] pack_data,
  output logic        adc_dovf,
  output logic        pack_err
);

  logic [3:0]        en, vld, en_q;
  logic [LANE_W-1:0] smp [LANES];
  logic [2:0]        n;
  logic              sup, strobe, mask_chg;
  logic [1:0]        ptr_q, ptr_d;
  logic [WORD_W-1:0] word_q, word_d, cmp_q, cmp_d;
  logic              cmp_vld_q, cmp_vld_d, err_q, dovf_q, fifo_drop;

  assign en     = {adc_enable_q1, adc_enable_i1, adc_enable_q0, adc_enable_i0};
  assign vld    = {adc_valid_q1, adc_valid_i1, adc_valid_q0, adc_valid_i0};
  assign smp[0] = adc_data_i0;
  assign smp[1] = adc_data_q0;
  assign smp[2] = adc_data_i1;
  assign smp[3] = adc_data_q1;

  always_comb begin
    n        = popcount4(en);
    sup      = count_ok(n);
    strobe   = |(en & vld);
    mask_chg = (en != en_q);
  end

  // A mask change restarts the word at lane 0; stale lanes are overwritten before completion.
  always_comb begin
    logic [1:0] lane;
    lane      = mask_chg ? 2'd0 : ptr_q;
    ptr_d     = lane;
    word_d    = word_q;
    cmp_d     = cmp_q;
    cmp_vld_d = 1'b0;
    if (strobe && sup) begin
      for (int ch = 0; ch < LANES; ch++) begin
        if (en[ch]) begin
          word_d[{lane, 4'b0000} +: LANE_W] = smp[ch];
          lane = lane + 2'd1;
        end
      end
      ptr_d = lane;
      if (lane == 2'd0) begin
        cmp_vld_d = 1'b1;
        cmp_d     = word_d;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      en_q      <= '0;
      ptr_q     <= '0;
      cmp_vld_q <= 1'b0;
      err_q     <= 1'b0;
      dovf_q    <= 1'b0;
    end else begin
      en_q      <= en;
      ptr_q     <= ptr_d;
      cmp_vld_q <= cmp_vld_d;
      err_q     <= ~sup;
      dovf_q    <= fifo_drop;
    end
  end

  always_ff @(posedge adc_clk) begin
    word_q <= word_d;
    cmp_q  <= cmp_d;
  end

  ad9361_rx_cpack_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (adc_clk),
    .rst_ni     (adc_rstn),
    .wr_i       (cmp_vld_q),
    .wr_data_i  (cmp_q),
    .rd_ready_i (pack_ready),
    .valid_o    (pack_valid),
    .data_o     (pack_data),
    .full_o     (),
    .drop_o     (fifo_drop)
  );

  assign adc_dovf = dovf_q;
  assign pack_err = err_q;

endmodule
